// File: rtl/trivium_rx_decrypt.sv
// Receive-side Trivium decryptor: eight keystream steps per clock XORed onto a valid/ready byte stream.
// Optional byte_count output (pt handshake counter) is built when TRIV_RX_BYTE_COUNT_EN is defined.
module trivium_rx_decrypt #(
    parameter logic [79:0] KEY          = 80'h9719CFC92A9FF688F9AA,
    parameter logic [79:0] IV           = 80'hECBB76B09AFF71D0D151,
    parameter int          WARMUP_STEPS = 1152
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        resync,
    input  logic        ct_valid,
    input  logic [7:0]  ct_data,
    output logic        ct_ready,
    output logic        pt_valid,
    output logic [7:0]  pt_data,
    input  logic        pt_ready,
    output logic        ks_live
`ifdef TRIV_RX_BYTE_COUNT_EN
    ,
    output logic [31:0] byte_count
`endif
);

    localparam int               WARMUP_CYCLES = WARMUP_STEPS / 8;
    localparam int               CNT_W         = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(WARMUP_CYCLES - 1);
    localparam logic [287:0]     LOAD_STATE    = {KEY, 13'b0, IV, 112'b0, 3'b111};

    typedef enum logic {WARMUP, RUN} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] warmCnt_q, warmCnt_d;
    logic [287:0]     trivState_q, trivState_d;
    logic             ptValid_q, ptValid_d;
    logic [7:0]       ptData_q, ptData_d;
    logic [287:0]     trivNext;
    logic [7:0]       ksByte;

    function automatic logic trivZ(input logic [287:0] s);
        return s[222] ^ s[195] ^ s[126] ^ s[111] ^ s[45] ^ s[0];
    endfunction

    function automatic logic [287:0] trivStep(input logic [287:0] s);
        logic t1, t2, t3;
        t1 = s[222] ^ s[195] ^ (s[196] & s[197]) ^ s[117];
        t2 = s[126] ^ s[111] ^ (s[112] & s[113]) ^ s[24];
        t3 = s[45]  ^ s[0]   ^ (s[2]   & s[1])   ^ s[219];
        return {t3, s[287:196], t1, s[194:112], t2, s[110:1]};
    endfunction

    // Step k of the chain supplies keystream bit k, so bit 0 is the oldest output.
    always_comb begin
        trivNext = trivState_q;
        ksByte   = '0;
        for (int k = 0; k < 8; k++) begin
            ksByte[k] = trivZ(trivNext);
            trivNext  = trivStep(trivNext);
        end
    end

    always_comb begin
        state_d     = state_q;
        warmCnt_d   = warmCnt_q;
        trivState_d = trivState_q;
        ptValid_d   = ptValid_q;
        ptData_d    = ptData_q;
        ct_ready    = 1'b0;
        if (resync) begin
            state_d     = WARMUP;
            warmCnt_d   = '0;
            trivState_d = LOAD_STATE;
            ptValid_d   = 1'b0;
            ptData_d    = '0;
        end else begin
            unique case (state_q)
                WARMUP: begin
                    trivState_d = trivNext;
                    warmCnt_d   = warmCnt_q + CNT_W'(1);
                    if (warmCnt_q == CNT_LAST) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    // The cipher only advances on an accepted byte, keeping both link ends in lockstep.
                    ct_ready = !rst && (!ptValid_q || pt_ready);
                    if (ct_valid && ct_ready) begin
                        ptData_d    = ct_data ^ ksByte;
                        ptValid_d   = 1'b1;
                        trivState_d = trivNext;
                    end else if (pt_ready) begin
                        ptValid_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= WARMUP;
            warmCnt_q   <= '0;
            trivState_q <= LOAD_STATE;
            ptValid_q   <= 1'b0;
            ptData_q    <= '0;
        end else begin
            state_q     <= state_d;
            warmCnt_q   <= warmCnt_d;
            trivState_q <= trivState_d;
            ptValid_q   <= ptValid_d;
            ptData_q    <= ptData_d;
        end
    end

    assign pt_valid = ptValid_q;
    assign pt_data  = ptData_q;
    assign ks_live  = (state_q == RUN);

`ifdef TRIV_RX_BYTE_COUNT_EN
    logic [31:0] byteCount_q, byteCount_d;

    always_comb begin
        byteCount_d = byteCount_q;
        if (resync) begin
            byteCount_d = '0;
        end else if (ptValid_q && pt_ready) begin
            byteCount_d = byteCount_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byteCount_q <= '0;
        end else begin
            byteCount_q <= byteCount_d;
        end
    end

    assign byte_count = byteCount_q;
`endif

endmodule

// File: tb/tb_trivium_rx_decrypt.sv
// Randomised bench for trivium_rx_decrypt: bit-serial Trivium reference plus byte scoreboard,
// with a second instance chained behind the first for the encrypt/decrypt round trip.
module tb_trivium_rx_decrypt;

    localparam logic [79:0] KEY           = 80'h9719CFC92A9FF688F9AA;
    localparam logic [79:0] IV            = 80'hECBB76B09AFF71D0D151;
    localparam int          WARMUP_STEPS  = 1152;
    localparam int          WARMUP_CYCLES = WARMUP_STEPS / 8;

    logic       clk = 1'b0;
    logic       rst, resync, ctValid, ptReady, bPtReady, chain;
    logic [7:0] ctData;
    logic       aCtReady, aPtValid, aKsLive, bCtReady, bPtValid, bKsLive;
    logic [7:0] aPtData, bPtData;
    logic       aPtReadyEff, bCtValid;
`ifdef TRIV_RX_BYTE_COUNT_EN
    logic [31:0] aByteCount, bByteCount;
`endif

    assign aPtReadyEff = chain ? bCtReady : ptReady;
    assign bCtValid    = chain & aPtValid;

    always #5 clk = ~clk;

    trivium_rx_decrypt #(.KEY(KEY), .IV(IV), .WARMUP_STEPS(WARMUP_STEPS)) uA (
        .clk(clk), .rst(rst), .resync(resync),
        .ct_valid(ctValid), .ct_data(ctData), .ct_ready(aCtReady),
        .pt_valid(aPtValid), .pt_data(aPtData), .pt_ready(aPtReadyEff),
        .ks_live(aKsLive)
`ifdef TRIV_RX_BYTE_COUNT_EN
        , .byte_count(aByteCount)
`endif
    );

    trivium_rx_decrypt #(.KEY(KEY), .IV(IV), .WARMUP_STEPS(WARMUP_STEPS)) uB (
        .clk(clk), .rst(rst), .resync(resync),
        .ct_valid(bCtValid), .ct_data(aPtData), .ct_ready(bCtReady),
        .pt_valid(bPtValid), .pt_data(bPtData), .pt_ready(bPtReady),
        .ks_live(bKsLive)
`ifdef TRIV_RX_BYTE_COUNT_EN
        , .byte_count(bByteCount)
`endif
    );

    int           checks, errors, ptFires;
    logic [287:0] refS;
    logic         benchLive, prevCtFire, lastCtFire, heldValid;
    logic [7:0]   heldData;
    logic [7:0]   expQ[$];
    logic [7:0]   rtQ[$];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic refLoad();
        refS = {KEY, 13'b0, IV, 112'b0, 3'b111};
    endtask

    task automatic refBit(output logic z);
        logic t1, t2, t3;
        z  = refS[222] ^ refS[195] ^ refS[126] ^ refS[111] ^ refS[45] ^ refS[0];
        t1 = refS[222] ^ refS[195] ^ (refS[196] & refS[197]) ^ refS[117];
        t2 = refS[126] ^ refS[111] ^ (refS[112] & refS[113]) ^ refS[24];
        t3 = refS[45]  ^ refS[0]   ^ (refS[2]   & refS[1])   ^ refS[219];
        refS = {t3, refS[287:196], t1, refS[194:112], t2, refS[110:1]};
    endtask

    task automatic refSkip();
        logic z;
        for (int i = 0; i < WARMUP_STEPS; i++) refBit(z);
    endtask

    task automatic refKsByte(output logic [7:0] b);
        logic z;
        b = '0;
        for (int k = 0; k < 8; k++) begin
            refBit(z);
            b[k] = z;
        end
    endtask

    // Evaluate handshakes on the falling edge, then advance to just after the next rising edge.
    task automatic cycleStep();
        logic       ctFire, ptFire, bFire;
        logic [7:0] ks, expByte;
        @(negedge clk);
        ctFire = ctValid & aCtReady;
        ptFire = aPtValid & aPtReadyEff & !resync;
        bFire  = bPtValid & bPtReady & !resync;
        checkOutput("ct_ready", 32'(aCtReady), 32'(benchLive & !resync & (!aPtValid | aPtReadyEff)));
        checkOutput("ks_live", 32'(aKsLive), 32'(benchLive));
        if (prevCtFire) checkOutput("pt_latency", 32'(aPtValid), 32'd1);
        if (heldValid) begin
            checkOutput("held_valid", 32'(aPtValid), 32'd1);
            checkOutput("held_data", 32'(aPtData), 32'(heldData));
        end
        if (ptFire) begin
            if (expQ.size() == 0) checkOutput("pt_spurious", 32'(aPtValid), 32'd0);
            else begin
                expByte = expQ.pop_front();
                checkOutput("pt_data", 32'(aPtData), 32'(expByte));
            end
            ptFires++;
        end
        if (bFire) begin
            if (rtQ.size() == 0) checkOutput("rt_spurious", 32'(bPtValid), 32'd0);
            else begin
                expByte = rtQ.pop_front();
                checkOutput("rt_data", 32'(bPtData), 32'(expByte));
            end
        end
        if (ctFire) begin
            refKsByte(ks);
            expQ.push_back(ctData ^ ks);
            if (chain) rtQ.push_back(ctData);
        end
        if (resync) begin
            expQ.delete();
            rtQ.delete();
        end
        prevCtFire = ctFire;
        lastCtFire = ctFire;
        heldValid  = aPtValid & !aPtReadyEff & !resync;
        heldData   = aPtData;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1; resync = 1'b0; ctValid = 1'b1; ctData = 8'h3C;
        ptReady = 1'b0; bPtReady = 1'b0; chain = 1'b0; benchLive = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_pt_valid", 32'(aPtValid), 32'd0);
        checkOutput("rst_pt_data", 32'(aPtData), 32'd0);
        checkOutput("rst_ct_ready", 32'(aCtReady), 32'd0);
        checkOutput("rst_ks_live", 32'(aKsLive), 32'd0);
`ifdef TRIV_RX_BYTE_COUNT_EN
        checkOutput("rst_byte_count", aByteCount, 32'd0);
`endif
        rst = 1'b0;
        refLoad();
        refSkip();
        for (int i = 0; i < WARMUP_CYCLES; i++) begin
            ctData = 8'($urandom);
            cycleStep();
        end
        benchLive = 1'b1;
        checkOutput("warm_ct_ready", 32'(aCtReady), 32'd1);
        checkOutput("warm_ks_live", 32'(aKsLive), 32'd1);
        ctValid = 1'b0;
    endtask

    task automatic doResync();
        resync = 1'b1;
        cycleStep();
        resync    = 1'b0;
        benchLive = 1'b0;
        checkOutput("resync_pt_valid", 32'(aPtValid), 32'd0);
        refLoad();
        refSkip();
        for (int i = 0; i < WARMUP_CYCLES; i++) begin
            ctValid = 1'b1;
            ctData  = 8'($urandom);
            cycleStep();
        end
        ctValid   = 1'b0;
        benchLive = 1'b1;
        checkOutput("resync_live", 32'(aKsLive), 32'd1);
    endtask

    task automatic applyStimulus(input int nBytes, input int readyPct, input bit randomData,
                                 input logic [7:0] firstByte, input bit drain, output int cycles);
        int sent;
        int limit;
        sent   = 0;
        limit  = nBytes * 20 + 50;
        cycles = 0;
        ctValid = 1'b1;
        ctData  = firstByte;
        while (sent < nBytes && cycles < limit) begin
            ptReady  = (int'($urandom_range(99)) < readyPct);
            bPtReady = (int'($urandom_range(99)) < readyPct);
            cycleStep();
            cycles++;
            if (lastCtFire) begin
                sent++;
                ctData = randomData ? 8'($urandom) : 8'h00;
            end
        end
        ctValid = 1'b0;
        if (sent != nBytes) checkOutput("stream_timeout", 32'(sent), 32'(nBytes));
        if (drain) begin
            ptReady  = 1'b1;
            bPtReady = 1'b1;
            for (int i = 0; i < 40 && (expQ.size() != 0 || rtQ.size() != 0); i++) cycleStep();
            checkOutput("drain_pt", 32'(expQ.size()), 32'd0);
            checkOutput("drain_rt", 32'(rtQ.size()), 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;
        int stallAccepts;
        checks = 0; errors = 0; ptFires = 0;
        prevCtFire = 1'b0; lastCtFire = 1'b0; heldValid = 1'b0; heldData = '0;

        doReset();

        applyStimulus(16, 100, 1'b0, 8'h00, 1'b1, cyc);
        checkOutput("ks_throughput", 32'(cyc), 32'd16);

        applyStimulus(40, 60, 1'b1, 8'($urandom), 1'b1, cyc);

        ctValid = 1'b1; ctData = 8'h5A; ptReady = 1'b1;
        cycleStep();
        ctData = 8'hC3; ptReady = 1'b0;
        stallAccepts = 0;
        repeat (5) begin
            cycleStep();
            stallAccepts += int'(lastCtFire);
        end
        checkOutput("bp_no_accept", 32'(stallAccepts), 32'd0);
        applyStimulus(4, 100, 1'b1, 8'hC3, 1'b1, cyc);

        applyStimulus(10, 80, 1'b1, 8'($urandom), 1'b0, cyc);
        ptReady = 1'b0;
        doResync();
        applyStimulus(1, 100, 1'b0, 8'h00, 1'b1, cyc);

        ptReady = 1'b0;
        doResync();
        checkOutput("b_live", 32'(bKsLive), 32'd1);
        chain = 1'b1;
        applyStimulus(64, 70, 1'b1, 8'hA5, 1'b1, cyc);
        chain = 1'b0;

`ifdef TRIV_RX_BYTE_COUNT_EN
        ptReady = 1'b0;
        doResync();
        checkOutput("bc_resync", aByteCount, 32'd0);
        ptFires = 0;
        applyStimulus(300, 100, 1'b1, 8'h11, 1'b1, cyc);
        checkOutput("bc_300", aByteCount, 32'd300);
        checkOutput("bc_model", aByteCount, 32'(ptFires));
        force uA.byteCount_q = 32'hFFFF_FFFF;
        #1;
        release uA.byteCount_q;
        applyStimulus(1, 100, 1'b1, 8'h22, 1'b1, cyc);
        checkOutput("bc_wrap", aByteCount, 32'd0);
        applyStimulus(3, 100, 1'b1, 8'h33, 1'b1, cyc);
        checkOutput("bc_three", aByteCount, 32'd3);
        doResync();
        checkOutput("bc_resync2", aByteCount, 32'd0);
        checkOutput("bc_b_resync", bByteCount, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
